alu_seq_multiplier: RTL

//  Iterative shift-add multiplier. Parametrised successor to the 16x16

---
 rtl/alu_seq_multiplier.sv | 125 ++++++++++++
 1 files changed

// File: rtl/alu_seq_multiplier.sv
// alu_seq_multiplier
// Iterative shift-add multiplier for the ALU. It produces one partial-product
// step per clock, so a result takes WIDTH+1 cycles after start is accepted.
// Signed operands are handled by multiplying the magnitudes and then negating
// the product when the operand signs differ.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        launch request, sampled only while idle
//   signed_mode  1: a, b and y are two's complement; 0: unsigned
//   a, b         operands, captured on the accepting edge
//   busy         high while an operation is in flight (RUN or FIN)
//   done         one-cycle registered pulse; y is valid from this cycle
//   y            2*WIDTH-bit product, held until the next done
//
// state | meaning
// IDLE  | waiting for start
// RUN   | WIDTH shift-add steps
// FIN   | sign fix-up, y/done update
module alu_seq_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   y
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [CW-1:0]    cnt;
    logic             neg;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic [PW-1:0]    prod;
    logic             last_step;

    // The magnitude of the most negative value still fits in WIDTH unsigned bits.
    assign a_mag = (signed_mode && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    assign b_mag = (signed_mode && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

    // The multiplier shifts out of lo while product bits shift in from hi.
    assign addend    = lo[0] ? mcand : '0;
    assign sum       = {1'b0, hi} + {1'b0, addend};
    assign prod      = {hi, lo};
    assign last_step = (cnt == CW'(WIDTH - 1));

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (last_step) next_state = FIN;
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
            cnt   <= '0;
            neg   <= 1'b0;
            done  <= 1'b0;
            y     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        mcand <= a_mag;
                        lo    <= b_mag;
                        hi    <= '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    hi  <= sum[WIDTH:1];
                    lo  <= {sum[0], lo[WIDTH-1:1]};
                    cnt <= cnt + CW'(1);
                end
                FIN: begin
                    y    <= neg ? (~prod + PW'(1)) : prod;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
